// File: rtl/usb_tx_cache.sv
// usb_tx_cache: ping-pong page buffer feeding the USB slave-FIFO writer (ifclk domain).
// Optional macro USB_TX_CACHE_HDR_EN prefixes every page with a 2-word header (A55A, page number).
//
// state  | meaning
// W_FILL | writing samples into bank wbank
// W_WAIT | page in wbank is full, waiting for the reader bank to be freed
// R_IDLE | reader bank holds no unread page
// R_BUSY | reader bank holds a handed-off page not yet read through its last word
module usb_tx_cache #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter int SOP_CYC = 2
) (
  input  logic              ifclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_vd,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_cache_sop,
  input  logic [ADDR_W-1:0] tx_cache_addr,
  output logic [DATA_W-1:0] tx_cache_data,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       page_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {W_FILL, W_WAIT} wstate_t;
  typedef enum logic {R_IDLE, R_BUSY} rstate_t;

  wstate_t             wstate, wstate_n;
  rstate_t             rstate, rstate_n;
  logic                wbank, wbank_n;
  logic [ADDR_W-1:0]   wptr, wptr_n;
  logic [2:0]          sop_cnt, sop_cnt_n;
  logic                ovf_n;
  logic [15:0]         drop_n, page_n;
  logic                we, swap, drop, release_rd, rd_free;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   mem [2*DEPTH];

`ifdef USB_TX_CACHE_HDR_EN
  localparam logic [15:0] HDR_WORD = 16'hA55A;
`endif

  // A release on the same edge as a swap frees the bank in time for the new page.
  assign release_rd   = (rstate == R_BUSY) && (tx_cache_addr == LAST);
  assign rd_free      = (rstate == R_IDLE) || release_rd;
  assign tx_cache_sop = (sop_cnt != 3'd0);

  always_comb begin
    wstate_n = wstate;
    wptr_n   = wptr;
    we       = 1'b0;
    wdata    = in_data;
    swap     = 1'b0;
    drop     = 1'b0;
    unique case (wstate)
      W_FILL: begin
        if (!enable) begin
          wptr_n = '0;
        end
`ifdef USB_TX_CACHE_HDR_EN
        else if (wptr < ADDR_W'(2)) begin
          we     = 1'b1;
          wdata  = (wptr == '0) ? DATA_W'(HDR_WORD) : DATA_W'(page_cnt + 16'd1);
          wptr_n = wptr + 1'b1;
          drop   = in_vd;
        end
`endif
        else if (in_vd) begin
          we     = 1'b1;
          wptr_n = wptr + 1'b1;
          if (wptr == LAST) begin
            if (rd_free) swap = 1'b1;
            else         wstate_n = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        drop = enable & in_vd;
        if (enable && rd_free) begin
          swap     = 1'b1;
          wstate_n = W_FILL;
        end
      end
    endcase

    wbank_n   = wbank;
    rstate_n  = release_rd ? R_IDLE : rstate;
    page_n    = page_cnt;
    sop_cnt_n = (sop_cnt != 3'd0) ? sop_cnt - 3'd1 : sop_cnt;
    if (swap) begin
      wbank_n   = ~wbank;
      wptr_n    = '0;
      rstate_n  = R_BUSY;
      page_n    = page_cnt + 16'd1;
      sop_cnt_n = 3'(SOP_CYC);
    end

    ovf_n  = ovf_flag;
    drop_n = drop_cnt;
    if (ovf_clr) begin
      ovf_n  = 1'b0;
      drop_n = '0;
    end else if (drop) begin
      ovf_n = 1'b1;
      if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge ifclk or negedge rst_n) begin
    if (!rst_n) begin
      wstate        <= W_FILL;
      rstate        <= R_IDLE;
      wbank         <= 1'b0;
      wptr          <= '0;
      sop_cnt       <= 3'd0;
      ovf_flag      <= 1'b0;
      drop_cnt      <= '0;
      page_cnt      <= '0;
      tx_cache_data <= '0;
    end else begin
      wstate        <= wstate_n;
      rstate        <= rstate_n;
      wbank         <= wbank_n;
      wptr          <= wptr_n;
      sop_cnt       <= sop_cnt_n;
      ovf_flag      <= ovf_n;
      drop_cnt      <= drop_n;
      page_cnt      <= page_n;
      tx_cache_data <= mem[{~wbank, tx_cache_addr}];
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge ifclk) begin
    if (we) mem[{wbank, wptr}] <= wdata;
  end

endmodule

// File: doc/usb_tx_cache.md
Name: usb_tx_cache

Overview:
- Ping-pong page buffer directly upstream of the USB slave-FIFO writer, in the ifclk domain.
- Accepts a sample stream, fills one bank while the writer drains the other, and announces each complete page with tx_cache_sop.
- Serves random reads on tx_cache_addr with fixed 1-cycle latency to tx_cache_data.
- Handles overflow by dropping samples and counting them.

Parameters:
- DATA_W, 16: sample/word width; equals `USB_DATA_NBIT.
- ADDR_W, 9: page address width; equals `USB_ADDR_NBIT; page = 2^ADDR_W words.
- SOP_CYC, 2: tx_cache_sop high time in cycles (1..7).

Ports:
- ifclk  in  1  48 MHz clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; low discards the partial page being filled.
- in_vd  in  1  sample valid strobe.
- in_data  in  DATA_W  sample.
- tx_cache_sop  out  1  page-ready pulse to the USB writer.
- tx_cache_addr  in  ADDR_W  read address from the USB writer.
- tx_cache_data  out  DATA_W  registered read data.
- ovf_flag  out  1  sticky: at least one sample dropped.
- ovf_clr  in  1  clears ovf_flag and drop_cnt.
- drop_cnt  out  16  dropped-sample count, saturating at 0xFFFF.
- page_cnt  out  16  pages handed off, wraps.

Behaviour:
- Reset (async assert, sync release): all outputs 0; wbank=0; wptr=0; write FSM W_FILL; read side R_IDLE; sop counter 0. RAM contents are undefined.
- Storage: two banks of 2^ADDR_W x DATA_W, selected by wbank.
  - Writes go to bank wbank.
  - Reads come from bank ~wbank.
  - tx_cache_data <= ram[~wbank][tx_cache_addr] every cycle, 1-cycle latency, independent of state.
- Write FSM:
  - W_FILL:
    - enable & in_vd: write in_data at wptr, wptr += 1 (wraps).
    - If the written wptr was all-ones (page complete):
      - rd_free true: perform swap, stay in W_FILL.
      - Otherwise: go to W_WAIT.
  - W_WAIT:
    - Every enable & in_vd is dropped: ovf_flag <= 1, drop_cnt += 1 (saturating).
    - When rd_free becomes true: perform swap, go to W_FILL.
  - rd_free = (read side R_IDLE) OR (release occurring this same cycle). Swap and release in the same cycle are legal and must not lose a page.
- Swap, as a single-cycle action:
  - wbank toggles, wptr <= 0.
  - Read side goes to R_BUSY.
  - page_cnt += 1.
  - Sop counter loads SOP_CYC.
- tx_cache_sop:
  - High while the sop counter is nonzero; the counter decrements each cycle.
  - First high cycle is the cycle after the swap edge.
  - Latency: last sample accepted at edge N -> tx_cache_sop high from N+1 to N+SOP_CYC, when the read side was free.
- Read side:
  - R_BUSY -> R_IDLE one cycle after tx_cache_addr is sampled equal to all-ones while in R_BUSY. The final word has been output by then.
  - In R_IDLE, addresses are still served (stale data); there are no side effects.
- enable low:
  - W_FILL: wptr <= 0 every cycle, partial page discarded.
  - W_WAIT: stay in W_WAIT; the full page is kept; in_vd is ignored and not counted.
  - The read side is unaffected.
- ovf_clr: clears ovf_flag and drop_cnt to 0. Clear takes priority over a same-cycle drop.
- Reset mid-operation: immediate return to reset state; a page in flight is abandoned; tx_cache_sop drops asynchronously.

Optional Feature:
- Macro: USB_TX_CACHE_HDR_EN.
- Defined:
  - Each page starts with a 2-word header inserted by the write side.
  - Word 0 = 16'hA55A, truncated/zero-extended to DATA_W.
  - Word 1 = page_cnt value the page will carry; page_cnt is pre-increment +1, so the first page carries 1.
  - Samples fill words 2..2^ADDR_W-1.
  - The header is written in the 2 cycles after wptr reset, using the sample write port. Any in_vd in those cycles is dropped and counted.
- Undefined: all 2^ADDR_W words are samples; no header logic is synthesised.

Test Plan:
- Basic fill: ADDR_W=4, enable=1, 16 consecutive in_vd with data 0..15 -> tx_cache_sop high exactly 2 cycles starting 1 cycle after the 16th sample; reading addr k returns k one cycle later; page_cnt=1.
- Ping-pong: stream 48 samples continuously while reading each page fully 0..15 after its sop -> 3 sop pulses, data 0..47 in order, drop_cnt=0.
- Overflow: fill 2 pages with no reads, then 5 more in_vd -> second page held in W_WAIT, drop_cnt=5, ovf_flag=1. Read addr 0..15 -> swap and sop next cycle, page_cnt=2. Assert ovf_clr -> flag and count 0.
- Simultaneous: schedule addr=15 sampling in R_BUSY on the same edge as a page-complete in W_WAIT -> swap occurs, no extra drop, sop fires.
- Enable drop: 7 samples, enable low 1 cycle, 16 samples 100..115 -> one page containing 100..115, no sop from the partial.
- Reset: assert rst_n low mid-sop -> sop and all outputs 0 asynchronously; after release, a new 16-sample page gives page_cnt=1. With USB_TX_CACHE_HDR_EN: addr0=A55A, addr1=0001, addr2=first sample.
